load_store_unit: RTL

Load/store unit between the sequential core's execute stage and the unified `Memory` block's data port. Accepts one load or store request at a time and handles RV32I access sizes (byte, halfword, word) with sign or zero extension. `Memory` only writes whole words, so the unit implements byte and halfword stores as a read-modify-write (RMW) sequence. It returns a single-cycle response carrying load data or a fault flag.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_if.sv | 43 ++++
 rtl/lsu_byte_lane.sv | 54 +++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size codes,
// FSM state encoding and the datapath width.
package lsu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_RD   = 3'd2,
        ST_STORE_WR = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Bundle of the core-side request/response and the Memory data-port signals.
// slave = the load/store unit, master = core plus Memory.
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_load;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_fault;

    lsu_state_t            state_dbg;

    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // the response is a one-cycle resp_valid pulse with no backpressure.
    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_addr, mem_wdata, mem_read, mem_write,
        output resp_valid, resp_rdata, resp_fault, state_dbg
    );

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_addr, mem_wdata, mem_read, mem_write,
        input  resp_valid, resp_rdata, resp_fault, state_dbg
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extraction with sign/zero extension and
// byte/halfword merge of store data into a word read from memory.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [15:0]           wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (funct3)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LBU:     load_data = {24'd0, byte_sel};
            LHU:     load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        if (funct3 == SB) begin
            case (offset)
                2'd0: merge_data[7:0]   = wdata[7:0];
                2'd1: merge_data[15:8]  = wdata[7:0];
                2'd2: merge_data[23:16] = wdata[7:0];
                2'd3: merge_data[31:24] = wdata[7:0];
                default: merge_data = rdata;
            endcase
        end else if (funct3 == SH) begin
            if (offset[1]) merge_data[31:16] = wdata;
            else           merge_data[15:0]  = wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, RV32I sizes, RMW for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
)(
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus
);

    lsu_state_t            state_q, state_d;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  fault_q;

    logic                  req_fault;
    logic                  is_half;
    logic                  is_word;
    logic                  misalign;
    logic [ADDR_WIDTH-1:0] addr_trunc;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;

    always_comb begin
        is_half = (bus.req_funct3[1:0] == 2'b01);
        is_word = (bus.req_funct3[1:0] == 2'b10);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (is_half && bus.req_addr[0]) || (is_word && (bus.req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        // Without the trap, misaligned addresses are silently truncated to the access size.
        addr_trunc = bus.req_addr;
        if (is_half) addr_trunc[0]   = 1'b0;
        if (is_word) addr_trunc[1:0] = 2'b00;

        req_fault = 1'b0;
        if (bus.req_load == bus.req_store) begin
            req_fault = 1'b1;
        end else if (bus.req_load) begin
            if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b111)
                req_fault = 1'b1;
        end else begin
            if (bus.req_funct3 != SB && bus.req_funct3 != SH && bus.req_funct3 != SW)
                req_fault = 1'b1;
        end
        if (misalign) req_fault = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_fault)                 state_d = ST_RESP;
                    else if (bus.req_load)         state_d = ST_LOAD;
                    else if (bus.req_funct3 == SW) state_d = ST_STORE_WR;
                    else                           state_d = ST_RMW_RD;
                end
            end
            ST_LOAD:     state_d = ST_RESP;
            ST_RMW_RD:   state_d = ST_STORE_WR;
            ST_STORE_WR: state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    lsu_byte_lane u_byte_lane (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .rdata      (bus.mem_rdata),
        .wdata      (word_q[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // word_q holds raw store data from accept, then the merged word after RMW_RD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_q <= 3'd0;
            addr_q   <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q <= bus.req_funct3;
                        addr_q   <= addr_trunc;
                        if (req_fault) begin
                            rdata_q <= '0;
                            fault_q <= 1'b1;
                        end else if (bus.req_store) begin
                            word_q <= bus.req_wdata;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata_q <= load_data;
                    fault_q <= 1'b0;
                end
                ST_RMW_RD: word_q <= merge_data;
                ST_STORE_WR: begin
                    rdata_q <= '0;
                    fault_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mem_read   = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    assign bus.mem_write  = (state_q == ST_STORE_WR);
    assign bus.mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata  = word_q;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
    assign bus.state_dbg  = state_q;

endmodule
